mem_access_ctrl: RTL
====================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, max wait-state cycles before abort (used only with MEM_TIMEOUT_EN).
REQ-002 Parameter CNT_W, default 8, width of the wait-state counter; TIMEOUT_CYCLES SHALL fit in CNT_W bits.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 Clear  input  1  synchronous, active-high reset.
REQ-005 rd_req  input  1  control-unit request for a memory read into MDR.
REQ-006 wr_req  input  1  control-unit request for a memory write from MDR.
REQ-007 mem_ack  input  1  memory reports the current access is complete.
REQ-008 mem_rd  output  1  memory read strobe.
REQ-009 mem_wr  output  1  memory write strobe.
REQ-010 MDRead  output  1  MDR mux select: 1 selects MDataIn.
REQ-011 MDRIn  output  1  MDR load enable.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 err  output  1  completion was a timeout abort; valid only while done is high.

Function
REQ-015 The FSM SHALL have the states IDLE, RD_WAIT, RD_LATCH, WR_WAIT and DONE; all outputs SHALL be Moore-decoded from the state register.
REQ-016 IDLE: rd_req -> RD_WAIT; else wr_req -> WR_WAIT; else stay; rd_req SHALL win when rd_req and wr_req are high in the same cycle.
REQ-017 RD_WAIT: mem_rd=1; mem_ack -> RD_LATCH; otherwise stay.
REQ-018 RD_LATCH: MDRead=1 and MDRIn=1 for exactly one cycle, so MDR captures MDataIn; next state DONE.
REQ-019 WR_WAIT: mem_wr=1, MDRead=0, MDRIn=0; mem_ack -> DONE.
REQ-020 DONE: done=1 for exactly one cycle; next state IDLE; a request is accepted again the cycle after DONE.
REQ-021 rd_req and wr_req SHALL be ignored outside IDLE; mem_ack SHALL be ignored in IDLE, RD_LATCH and DONE.
REQ-022 Latency with mem_ack high on the first wait cycle: read done 3 cycles after the request edge; write done 2 cycles after the request edge; each extra ack-low wait cycle adds one cycle.
REQ-023 mem_rd and mem_wr SHALL never be high together; MDRIn SHALL be high only in RD_LATCH.

Reset
REQ-024 Clear sampled high at a posedge SHALL force IDLE from any state, aborting any access in progress without pulsing done.
REQ-025 Clear SHALL zero the wait counter.
REQ-026 After Clear, all outputs SHALL be 0 (mem_rd, mem_wr, MDRead, MDRIn, busy, done, err).
REQ-027 Clear SHALL take priority over every request and over mem_ack.

Configuration
REQ-028 Macro MEM_TIMEOUT_EN defined: a CNT_W-bit counter SHALL clear on entry to RD_WAIT or WR_WAIT and increment each wait cycle without mem_ack.
REQ-029 With the macro, when the counter reaches TIMEOUT_CYCLES without mem_ack, the FSM SHALL go to DONE with err=1, skipping RD_LATCH so the MDR is not loaded.
REQ-030 Macro undefined: no counter SHALL be built, err SHALL be tied 0, and wait states SHALL be unbounded.

Structure
REQ-031 Package mem_ctrl_pkg SHALL hold the state encoding constants (3-bit, IDLE=0) and the default CNT_W and TIMEOUT_CYCLES constants.
REQ-032 The timeout counter SHALL be the sub-module mem_timeout_cnt, instantiated only under MEM_TIMEOUT_EN.

Verification
REQ-033 Clear high with rd_req high -> all outputs 0; state stays IDLE.
REQ-034 rd_req pulse, mem_ack high on the first RD_WAIT cycle -> mem_rd 1 cycle, MDRead/MDRIn 1 cycle, done 3 cycles after the request; MDR holds 0xDEADBEEF from MDataIn.
REQ-035 wr_req with mem_ack delayed 4 cycles -> mem_wr high 5 cycles; done 6 cycles after the request; MDRIn never high.
REQ-036 rd_req and wr_req high together -> read path taken; wr_req held high afterwards -> write starts the cycle after DONE.
REQ-037 Clear asserted in RD_WAIT cycle 2 -> IDLE next cycle; no done pulse; no MDRIn pulse.
REQ-038 MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, mem_ack never high -> done=1 and err=1 after 4 wait cycles; MDRIn never high.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and default sizing for the memory access controller.
// Optional timeout abort is enabled with the MEM_TIMEOUT_EN macro.
package mem_ctrl_pkg;

  localparam int CNT_W_DEF          = 8;
  localparam int TIMEOUT_CYCLES_DEF = 255;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_WAIT  = 3'd1,
    RD_LATCH = 3'd2,
    WR_WAIT  = 3'd3,
    DONE     = 3'd4
  } state_t;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Handshake bundle between the control unit, memory and the access controller.
interface mem_access_ctrl_if;

  logic rd_req;
  logic wr_req;
  logic mem_ack;
  logic mem_rd;
  logic mem_wr;
  logic MDRead;
  logic MDRIn;
  logic busy;
  logic done;
  logic err;

  modport slave (
    input  rd_req, wr_req, mem_ack,
    output mem_rd, mem_wr, MDRead, MDRIn, busy, done, err
  );

  modport master (
    output rd_req, wr_req, mem_ack,
    input  mem_rd, mem_wr, MDRead, MDRIn, busy, done, err
  );

endinterface

// File: rtl/mem_timeout_cnt.sv
// Wait-state counter: flags the TIMEOUT_CYCLES-th consecutive ack-less wait cycle.
// Only instantiated when MEM_TIMEOUT_EN is defined.
module mem_timeout_cnt
  import mem_ctrl_pkg::*;
#(
  parameter int CNT_W          = CNT_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic srst,
  input  logic run,
  input  logic ack,
  output logic expire
);

  logic [CNT_W-1:0] cnt_reg;

  // Held at zero outside the wait states, so every wait entry starts from 0.
  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_reg <= '0;
    end else if (!run) begin
      cnt_reg <= '0;
    end else if (!ack) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign expire = run && !ack && (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_access_ctrl.sv
// Moore FSM sequencing memory reads into the MDR and writes from it.
// Define MEM_TIMEOUT_EN to abort stalled accesses after TIMEOUT_CYCLES waits.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int CNT_W          = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               Clear,
  mem_access_ctrl_if.slave   bus
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= (2 ** CNT_W)) begin : g_bad_cfg
    $error("TIMEOUT_CYCLES must be in 1 .. 2**CNT_W-1");
  end

  state_t state_reg;
  state_t state_next;
  logic   timeout;
  logic   in_wait;

  assign in_wait = (state_reg == RD_WAIT) || (state_reg == WR_WAIT);

`ifdef MEM_TIMEOUT_EN
  logic err_reg;

  mem_timeout_cnt #(
    .CNT_W          (CNT_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk    (clk),
    .srst   (Clear),
    .run    (in_wait),
    .ack    (bus.mem_ack),
    .expire (timeout)
  );

  // A timeout always moves the FSM to DONE, so this flag is set exactly for that DONE cycle.
  always_ff @(posedge clk) begin
    if (Clear) begin
      err_reg <= 1'b0;
    end else begin
      err_reg <= timeout;
    end
  end

  assign bus.err = err_reg && (state_reg == DONE);
`else
  assign timeout = 1'b0;
  assign bus.err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (Clear) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.rd_req) begin
          state_next = RD_WAIT;
        end else if (bus.wr_req) begin
          state_next = WR_WAIT;
        end
      end
      RD_WAIT: begin
        if (bus.mem_ack) begin
          state_next = RD_LATCH;
        end else if (timeout) begin
          state_next = DONE;
        end
      end
      RD_LATCH: state_next = DONE;
      WR_WAIT: begin
        if (bus.mem_ack || timeout) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_rd = 1'b0;
    bus.mem_wr = 1'b0;
    bus.MDRead = 1'b0;
    bus.MDRIn  = 1'b0;
    bus.done   = 1'b0;
    bus.busy   = (state_reg != IDLE);
    case (state_reg)
      RD_WAIT:  bus.mem_rd = 1'b1;
      RD_LATCH: begin
        bus.MDRead = 1'b1;
        bus.MDRIn  = 1'b1;
      end
      WR_WAIT:  bus.mem_wr = 1'b1;
      DONE:     bus.done   = 1'b1;
      default:  ;
    endcase
  end

endmodule
